// File: rtl/tff_multimode_bank.sv
// Bank of WIDTH flip-flops, each a T flip-flop core whose toggle input is
// derived from (a, b) according to a run-time SR/JK/D/T mode register.
module tff_multimode_bank #(
  parameter int               WIDTH      = 8,
  parameter int               CNT_W      = 8,
  parameter int               SR_ILLEGAL = 0,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode_wr,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clear_stats,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             illegal_flag,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mode_e            mode_q;
  logic [WIDTH-1:0] q_q;
  logic             illegal_flag_q;
  logic [CNT_W-1:0] illegal_cnt_q;
  logic [CNT_W-1:0] toggle_cnt_q;

  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] illegal_bits;
  logic [WIDTH-1:0] sr_policy_t;
  logic [WIDTH-1:0] set_reset_t;
  logic             illegal_ev;
  logic             toggle_ev;

  assign illegal_bits = a & b;
  assign set_reset_t  = (a & ~q_q) | (b & q_q);

  // Toggle value applied to bits with S=R=1; "force" means toggle only if q differs.
  always_comb begin
    sr_policy_t = '0;
    case (SR_ILLEGAL)
      1:       sr_policy_t = q_q;
      2:       sr_policy_t = ~q_q;
      3:       sr_policy_t = '1;
      default: sr_policy_t = '0;
    endcase
  end

  always_comb begin
    t_d = '0;
    case (mode_q)
      MODE_SR: t_d = (set_reset_t & ~illegal_bits) | (sr_policy_t & illegal_bits);
      MODE_JK: t_d = set_reset_t;
      MODE_D:  t_d = a ^ q_q;
      MODE_T:  t_d = a;
      default: t_d = '0;
    endcase
  end

  assign illegal_ev = (mode_q == MODE_SR) && (|illegal_bits);
  assign toggle_ev  = |t_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q         <= MODE_SR;
      q_q            <= RESET_VAL;
      illegal_flag_q <= 1'b0;
      illegal_cnt_q  <= '0;
      toggle_cnt_q   <= '0;
    end else begin
      // The update below always sees the mode that was current before this edge.
      if (mode_wr) mode_q <= mode_e'(mode_in);
      if (en) q_q <= q_q ^ t_d;
      if (clear_stats) begin
        illegal_flag_q <= 1'b0;
        illegal_cnt_q  <= '0;
        toggle_cnt_q   <= '0;
      end else if (en) begin
        if (illegal_ev) begin
          illegal_flag_q <= 1'b1;
          if (illegal_cnt_q != CNT_MAX) illegal_cnt_q <= illegal_cnt_q + CNT_ONE;
        end
        if (toggle_ev && (toggle_cnt_q != CNT_MAX)) toggle_cnt_q <= toggle_cnt_q + CNT_ONE;
      end
    end
  end

  assign mode         = mode_q;
  assign q            = q_q;
  assign qbar         = ~q_q;
  assign illegal_flag = illegal_flag_q;
  assign illegal_cnt  = illegal_cnt_q;
  assign toggle_cnt   = toggle_cnt_q;

endmodule

// File: tb/tb_tff_multimode_bank.sv
// Bench for tff_multimode_bank: four instances (one per illegal-SR policy) share
// stimulus and are compared each cycle against a characteristic-equation model.
module tb_tff_multimode_bank;

  logic       clk;
  logic       reset;
  logic       en;
  logic       mode_wr;
  logic [1:0] mode_in;
  logic [7:0] a;
  logic [7:0] b;
  logic       clear_stats;

  logic [1:0] md0, md1, md2, md3;
  logic [7:0] q0, q1, q2, q3;
  logic [7:0] qb0, qb1, qb2, qb3;
  logic       f0, f1, f2, f3;
  logic [7:0] ic0, ic2, ic3, tc0, tc2, tc3;
  logic [1:0] ic1, tc1;

  int n_cmp;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  tff_multimode_bank #(.WIDTH(8), .CNT_W(8), .SR_ILLEGAL(3), .RESET_VAL(8'hA5)) u0 (
    .clk(clk), .reset(reset), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
    .a(a), .b(b), .clear_stats(clear_stats), .mode(md0), .q(q0), .qbar(qb0),
    .illegal_flag(f0), .illegal_cnt(ic0), .toggle_cnt(tc0));
  tff_multimode_bank #(.WIDTH(8), .CNT_W(2), .SR_ILLEGAL(0), .RESET_VAL(8'h00)) u1 (
    .clk(clk), .reset(reset), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
    .a(a), .b(b), .clear_stats(clear_stats), .mode(md1), .q(q1), .qbar(qb1),
    .illegal_flag(f1), .illegal_cnt(ic1), .toggle_cnt(tc1));
  tff_multimode_bank #(.WIDTH(8), .CNT_W(8), .SR_ILLEGAL(1), .RESET_VAL(8'h00)) u2 (
    .clk(clk), .reset(reset), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
    .a(a), .b(b), .clear_stats(clear_stats), .mode(md2), .q(q2), .qbar(qb2),
    .illegal_flag(f2), .illegal_cnt(ic2), .toggle_cnt(tc2));
  tff_multimode_bank #(.WIDTH(8), .CNT_W(8), .SR_ILLEGAL(2), .RESET_VAL(8'h00)) u3 (
    .clk(clk), .reset(reset), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
    .a(a), .b(b), .clear_stats(clear_stats), .mode(md3), .q(q3), .qbar(qb3),
    .illegal_flag(f3), .illegal_cnt(ic3), .toggle_cnt(tc3));

  // ---------------- reference model ----------------
  int         pol_m [4] = '{3, 0, 1, 2};
  int         cmax_m[4] = '{255, 3, 255, 255};
  logic [7:0] rv_m  [4] = '{8'hA5, 8'h00, 8'h00, 8'h00};
  logic [7:0] mq    [4];
  int         mtc   [4];
  int         mic   [4];
  logic       mflag [4];
  logic [1:0] mmode;

  // Next state of one bit from the textbook characteristic tables.
  function automatic logic next_bit(input logic [1:0] md, input int pol,
                                    input logic x, input logic y, input logic cur);
    case (md)
      2'd0: begin
        if (x && y) begin
          case (pol)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~cur;
            default: return cur;
          endcase
        end
        if (x) return 1'b1;
        if (y) return 1'b0;
        return cur;
      end
      2'd1: begin
        if (x && y) return ~cur;
        if (x) return 1'b1;
        if (y) return 1'b0;
        return cur;
      end
      2'd2:    return x;
      default: return cur ^ x;
    endcase
  endfunction

  task automatic model_apply();
    logic [7:0] nq;
    logic       illegal;
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        mq[k] = rv_m[k]; mtc[k] = 0; mic[k] = 0; mflag[k] = 1'b0;
      end else begin
        for (int i = 0; i < 8; i++) nq[i] = next_bit(mmode, pol_m[k], a[i], b[i], mq[k][i]);
        illegal = (mmode == 2'd0) && ((a & b) != 8'h00);
        if (clear_stats) begin
          mtc[k] = 0; mic[k] = 0; mflag[k] = 1'b0;
        end else if (en) begin
          if (illegal) begin
            mflag[k] = 1'b1;
            if (mic[k] < cmax_m[k]) mic[k]++;
          end
          if (nq != mq[k] && mtc[k] < cmax_m[k]) mtc[k]++;
        end
        if (en) mq[k] = nq;
      end
    end
    if (reset) mmode = 2'd0;
    else if (mode_wr) mmode = mode_in;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int k, input logic [1:0] md, input logic [7:0] qq,
                          input logic [7:0] qb, input logic fl, input logic [7:0] ic,
                          input logic [7:0] tc);
    chk($sformatf("u%0d.q", k), qq, mq[k]);
    chk($sformatf("u%0d.qbar", k), qb, ~mq[k]);
    chk($sformatf("u%0d.mode", k), {6'd0, md}, {6'd0, mmode});
    chk($sformatf("u%0d.illegal_flag", k), {7'd0, fl}, {7'd0, mflag[k]});
    chk($sformatf("u%0d.illegal_cnt", k), ic, mic[k][7:0]);
    chk($sformatf("u%0d.toggle_cnt", k), tc, mtc[k][7:0]);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic e, input logic wr, input logic [1:0] mi,
                       input logic [7:0] av, input logic [7:0] bv, input logic clr);
    reset = rst; en = e; mode_wr = wr; mode_in = mi; a = av; b = bv; clear_stats = clr;
  endtask

  task automatic step();
    @(posedge clk);
    model_apply();
    #1;
    chk_inst(0, md0, q0, qb0, f0, ic0, tc0);
    chk_inst(1, md1, q1, qb1, f1, {6'd0, ic1}, {6'd0, tc1});
    chk_inst(2, md2, q2, qb2, f2, ic2, tc2);
    chk_inst(3, md3, q3, qb3, f3, ic3, tc3);
  endtask

  // ---------------- directed vectors (expectations for u0) ----------------
  typedef struct {
    logic       rst, en, wr;
    logic [1:0] mi;
    logic [7:0] a, b;
    logic       clr;
    logic [7:0] eq;
    logic [1:0] emode;
    logic [7:0] etc, eic;
    logic       eflag;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic e, input logic wr, input logic [1:0] mi,
                              input logic [7:0] av, input logic [7:0] bv, input logic clr,
                              input logic [7:0] eq, input logic [1:0] em, input logic [7:0] etc,
                              input logic [7:0] eic, input logic ef);
    vec_t v;
    v.rst = rst; v.en = e; v.wr = wr; v.mi = mi; v.a = av; v.b = bv; v.clr = clr;
    v.eq = eq; v.emode = em; v.etc = etc; v.eic = eic; v.eflag = ef;
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);

    //              rst en wr mi  a      b      clr  q      mode tcnt icnt flag
    tbl[0]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 8'h0F, 8'h00, 0, 8'h0F, 0, 2, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 8'h00, 8'h03, 0, 8'h0C, 0, 3, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 8'h81, 8'h81, 0, 8'h8D, 0, 4, 1, 1);
    tbl[5]  = mk(0, 1, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 5, 1, 1);
    tbl[6]  = mk(0, 1, 1, 2, 8'hFF, 8'h00, 0, 8'hFF, 2, 6, 1, 1);
    tbl[7]  = mk(0, 1, 0, 0, 8'h3C, 8'h00, 0, 8'h3C, 2, 7, 1, 1);
    tbl[8]  = mk(0, 1, 1, 3, 8'h00, 8'h00, 0, 8'h00, 3, 8, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 8'hFF, 8'h00, 0, 8'h00, 3, 8, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 8'hFF, 8'h00, 0, 8'h00, 3, 8, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 8'hFF, 8'h00, 0, 8'h00, 3, 8, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 8'hFF, 8'h00, 0, 8'h00, 3, 8, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 8'hFF, 8'h00, 0, 8'h00, 3, 8, 1, 1);
    tbl[14] = mk(0, 1, 0, 0, 8'hFF, 8'h00, 0, 8'hFF, 3, 9, 1, 1);
    tbl[15] = mk(0, 1, 0, 0, 8'h00, 8'h00, 1, 8'hFF, 3, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 1, 8'h00, 8'h00, 0, 8'hFF, 1, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 8'h01, 8'h01, 0, 8'hFE, 1, 1, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 8'h01, 8'h01, 0, 8'hFF, 1, 2, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 8'h01, 8'h01, 0, 8'hFE, 1, 3, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 8'h01, 8'h01, 0, 8'hFF, 1, 4, 0, 0);
    tbl[21] = mk(0, 1, 0, 0, 8'h01, 8'h01, 0, 8'hFE, 1, 5, 0, 0);
    tbl[22] = mk(0, 1, 0, 0, 8'h01, 8'h01, 0, 8'hFF, 1, 6, 0, 0);
    tbl[23] = mk(0, 1, 0, 0, 8'h01, 8'h01, 1, 8'hFE, 1, 0, 0, 0);
    tbl[24] = mk(0, 1, 0, 0, 8'hFF, 8'hFF, 0, 8'h01, 1, 1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].mi, tbl[i].a, tbl[i].b, tbl[i].clr);
      step();
      chk($sformatf("vec%0d.q", i), q0, tbl[i].eq);
      chk($sformatf("vec%0d.qbar", i), qb0, ~tbl[i].eq);
      chk($sformatf("vec%0d.mode", i), {6'd0, md0}, {6'd0, tbl[i].emode});
      chk($sformatf("vec%0d.toggle_cnt", i), tc0, tbl[i].etc);
      chk($sformatf("vec%0d.illegal_cnt", i), ic0, tbl[i].eic);
      chk($sformatf("vec%0d.illegal_flag", i), {7'd0, f0}, {7'd0, tbl[i].eflag});
      if (i == 4) begin
        chk("hold_policy.q", q1, 8'h0C);
        chk("hold_policy.illegal_cnt", {6'd0, ic1}, 8'd1);
      end
      if (i == 22) chk("sat2.toggle_cnt", {6'd0, tc1}, 8'd3);
      if (i == 23) chk("sat2.clear", {6'd0, tc1}, 8'd0);
    end

    // Reset coinciding with mode write, enable and clear: reset wins.
    drive(0, 1, 0, 0, 8'h5A, 8'h00, 0);
    step();
    drive(1, 1, 1, 2'd3, 8'hFF, 8'hFF, 1);
    step();
    chk("rst_prio.q", q0, 8'hA5);
    chk("rst_prio.qbar", qb0, 8'h5A);
    chk("rst_prio.mode", {6'd0, md0}, 8'd0);

    // Sticky flag survives legal SR traffic until cleared.
    drive(0, 1, 0, 0, 8'h10, 8'h10, 0);
    step();
    drive(0, 1, 0, 0, 8'h00, 8'h00, 0);
    step();
    step();
    chk("sticky.flag", {7'd0, f0}, 8'd1);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 15) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tff_multimode_bank.md
Name: tff_multimode_bank

Overview:
- WIDTH-channel flip-flop bank. Every channel is built on a single T flip-flop core: q <= q ^ t.
- A run-time mode register selects how the channel inputs become t. Modes are SR, JK, D and T.
- A configurable policy handles the illegal SR input (S=R=1). Illegal inputs also raise a sticky error flag and increment a saturating counter.
- A saturating activity counter records cycles in which any bit toggled.
- The block replaces single-bit FF-type converters in control and state-register paths.

Parameters:
- WIDTH, 8, number of flip-flop channels.
- CNT_W, 8, width of the illegal_cnt and toggle_cnt statistics counters.
- SR_ILLEGAL, 0, per-bit action on S=R=1 in SR mode: 0 hold, 1 force 0, 2 force 1, 3 toggle.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  update enable. When low, q holds and no statistics change.
- mode_wr  in  1  write strobe for the mode register.
- mode_in  in  2  new mode: 00 SR, 01 JK, 10 D, 11 T.
- a  in  WIDTH  per-channel first input: S, J, D or T depending on mode.
- b  in  WIDTH  per-channel second input: R or K. Ignored in D and T modes.
- clear_stats  in  1  clears illegal_cnt, toggle_cnt and illegal_flag.
- mode  out  2  current mode register value.
- q  out  WIDTH  flip-flop state.
- qbar  out  WIDTH  ~q, combinational.
- illegal_flag  out  1  sticky; set by any illegal SR input while en is high.
- illegal_cnt  out  CNT_W  count of enabled cycles with at least one illegal SR bit; saturating.
- toggle_cnt  out  CNT_W  count of enabled cycles with t!=0; saturating.

Behaviour:
- Reset (reset high at posedge) sets:
  - q = RESET_VAL
  - mode = 00 (SR)
  - illegal_flag = 0, illegal_cnt = 0, toggle_cnt = 0
- Reset has priority over mode_wr, en and clear_stats in the same cycle.
- t vector is computed combinationally from the current (registered) mode, a, b and q:
  - SR: t = (a&~q)|(b&q) on legal bits. For bits where a&b=1, apply SR_ILLEGAL: hold t=0; force 0 t=q; force 1 t=~q; toggle t=1.
  - JK: t = (a&~q)|(b&q). J=K=1 toggles.
  - D: t = a^q.
  - T: t = a.
- State update: when en=1, q <= q ^ t at the next posedge. Latency is one cycle from input to q.
- When en=0, q holds whatever a, b and mode are.
- Mode write:
  - On mode_wr=1, mode <= mode_in at the posedge.
  - An update in that same cycle uses the OLD mode; the new mode applies from the next cycle.
  - mode_wr is independent of en.
- Statistics (evaluated only when en=1 and reset=0):
  - illegal event: mode==SR and |(a&b). It sets illegal_flag and increments illegal_cnt.
  - toggle event: |t. It increments toggle_cnt. A bit forced to its current value is not a toggle.
  - Both counters stop at {CNT_W{1'b1}} and never wrap.
- clear_stats=1 zeroes both counters and illegal_flag at the posedge.
  - clear_stats wins over a coincident event; that event is not counted.
  - clear_stats does not affect q or mode.
- Illegal events are defined only in SR mode. JK with J=K=1 is legal.
- qbar always equals ~q, including during and right after reset.

Test Plan:
1. Reset, WIDTH=8, RESET_VAL=8'hA5 -> q=A5, qbar=5A, mode=00, all stats 0 on the cycle after reset.
2. SR mode from q=00, en=1:
   - a=0F, b=00 -> q=0F.
   - Then a=00, b=03 -> q=0C.
   - toggle_cnt=2, illegal_flag=0.
3. SR_ILLEGAL=3, q=0C, a=b=81 for one cycle -> q=8D, illegal_flag=1, illegal_cnt=1.
   - Repeat with SR_ILLEGAL=0: q stays 0C, illegal_cnt=1.
4. Mode change:
   - In one cycle: mode_wr=1, mode_in=10 (D), a=FF, b=00, q=00 -> q=FF (SR set via old mode), mode=10.
   - Next cycle a=3C -> q=3C.
5. T mode with en=0, a=FF for 5 cycles -> q unchanged, toggle_cnt unchanged. en=1 for 1 cycle -> q inverted.
6. CNT_W=2, JK mode, J=K=01 for 6 enabled cycles -> toggle_cnt saturates at 3, q[0] alternates each cycle.
   - clear_stats coincident with a toggle -> toggle_cnt=0, q still toggles.
